// File: rtl/net_lane_deserializer.sv
// net_lane_deserializer
// Multi-lane TSPIN packet receiver. Each serial lane first hunts for SYNCWORD.
// It then shifts in PAYLOAD_BITS of encoded payload, MSB-first. The lanes are
// aligned within a window of SKEW_MAX cycles. The concatenated payload is then
// held in an output register that drives a valid/ready handshake.
//
// Optional build macro: NET_RX_LANE_SEQ_CHECK_EN
//   When it is defined, bit 0 of each lane payload is a lane sequence tag.
//   A completed group whose tags disagree is discarded and reported on skew_err.
module net_lane_deserializer #(
   parameter int                   NUM_LANES    = 4,
   parameter int                   PAYLOAD_BITS = 217,
   parameter int                   SYNC_BITS    = 8,
   parameter logic [SYNC_BITS-1:0] SYNCWORD     = 8'hff,
   parameter int                   SKEW_MAX     = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_LANES-1:0]              serial_in,
   input  logic                              rx_enable,
   output logic [NUM_LANES*PAYLOAD_BITS-1:0] pkt_data,
   output logic                              pkt_valid,
   input  logic                              pkt_ready,
   output logic                              overrun,
   output logic                              skew_err
);

   localparam int                CNT_W      = $clog2(PAYLOAD_BITS + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(PAYLOAD_BITS - 1);
   localparam logic [7:0]        SKEW_LIMIT = 8'(SKEW_MAX);

   localparam logic [1:0] ST_HUNT = 2'd0;
   localparam logic [1:0] ST_RECV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Per-lane state
   logic [1:0]              state_q [NUM_LANES];
   logic [1:0]              state_d [NUM_LANES];
   logic [SYNC_BITS-1:0]    sync_q  [NUM_LANES];
   logic [SYNC_BITS-1:0]    sync_d  [NUM_LANES];
   logic [PAYLOAD_BITS-1:0] pay_q   [NUM_LANES];
   logic [PAYLOAD_BITS-1:0] pay_d   [NUM_LANES];
   logic [CNT_W-1:0]        cnt_q   [NUM_LANES];
   logic [CNT_W-1:0]        cnt_d   [NUM_LANES];

   // Group alignment and output state
   logic [7:0]                          skew_q, skew_d;
   logic [NUM_LANES*PAYLOAD_BITS-1:0]   data_q, data_d;
   logic                                valid_q, valid_d;
   logic                                overrun_q, overrun_d;
   logic                                skew_err_q, skew_err_d;

   // Group-level decisions
   logic                                all_done, any_enter;
   logic                                abort, complete, skew_fail, release_lanes;
   logic                                tag_ok, pkt_in, tag_err;
   logic [NUM_LANES*PAYLOAD_BITS-1:0]   new_pkt;
   logic [SYNC_BITS:0]                  sync_shift;

   // Summarise lane progress: are all lanes DONE, and is any lane finishing now?
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
      all_done  = 1'b1;
      any_enter = 1'b0;
      new_pkt   = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (state_q[i] != ST_DONE) all_done = 1'b0;
         if (state_q[i] == ST_RECV && cnt_q[i] == LAST_BIT) any_enter = 1'b1;
         new_pkt[i*PAYLOAD_BITS +: PAYLOAD_BITS] = pay_q[i];
      end
   end

   // Compare lane sequence tags; with the check compiled out every group is accepted.
   always_comb begin
      tag_ok = 1'b1;
`ifdef NET_RX_LANE_SEQ_CHECK_EN
      for (int i = 1; i < NUM_LANES; i++) begin
         if (pay_q[i][0] != pay_q[0][0]) tag_ok = 1'b0;
      end
`else
      tag_ok = 1'b1;
`endif
   end

   // A disable aborts quietly. Completion and skew overflow both send the lane group back to HUNT.
   always_comb begin
      abort         = !rx_enable;
      complete      = rx_enable && all_done;
      skew_fail     = rx_enable && !all_done && (skew_q == SKEW_LIMIT);
      release_lanes = abort || complete || skew_fail;
      pkt_in        = complete && tag_ok;
      tag_err       = complete && !tag_ok;
   end

   // Per-lane HUNT/RECV/DONE next state. The syncword is not searched for while in RECV.
   always_comb begin
      sync_shift = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         state_d[i] = state_q[i];
         sync_d[i]  = sync_q[i];
         pay_d[i]   = pay_q[i];
         cnt_d[i]   = cnt_q[i];
         if (release_lanes) begin
            state_d[i] = ST_HUNT;
            sync_d[i]  = '0;
            cnt_d[i]   = '0;
            if (abort) pay_d[i] = '0;
         end else begin
            case (state_q[i])
               ST_HUNT: begin
                  sync_shift = {sync_q[i], serial_in[i]};
                  sync_d[i]  = sync_shift[SYNC_BITS-1:0];
                  if (sync_shift[SYNC_BITS-1:0] == SYNCWORD) begin
                     state_d[i] = ST_RECV;
                     cnt_d[i]   = '0;
                  end
               end
               ST_RECV: begin
                  pay_d[i] = {pay_q[i][PAYLOAD_BITS-2:0], serial_in[i]};
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  if (cnt_q[i] == LAST_BIT) state_d[i] = ST_DONE;
               end
               ST_DONE: ;
               default: state_d[i] = ST_HUNT;
            endcase
         end
      end
   end

   // Skew counter. It starts at 1 when the first lane finishes and runs while the group is only partly DONE.
   always_comb begin
      skew_d = skew_q;
      if (release_lanes)       skew_d = 8'd0;
      else if (skew_q != 8'd0) skew_d = skew_q + 8'd1;
      else if (any_enter)      skew_d = 8'd1;
   end

   // Output holding register. A completion while FULL is dropped unless the consumer takes the old packet on the same edge.
   always_comb begin
      data_d     = data_q;
      valid_d    = valid_q;
      overrun_d  = 1'b0;
      skew_err_d = skew_fail || tag_err;
      if (pkt_in) begin
         if (!valid_q || pkt_ready) begin
            data_d  = new_pkt;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && pkt_ready) begin
         valid_d = 1'b0;
      end
   end

   // Lane registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the lane arrays are reset too, because hunting depends on the sync registers starting from zero.
         for (int i = 0; i < NUM_LANES; i++) begin
            state_q[i] <= ST_HUNT;
            sync_q[i]  <= '0;
            pay_q[i]   <= '0;
            cnt_q[i]   <= '0;
         end
      end else begin
         // NOTE: all state uses non-blocking assignment, so every register updates from pre-edge values.
         for (int i = 0; i < NUM_LANES; i++) begin
            state_q[i] <= state_d[i];
            sync_q[i]  <= sync_d[i];
            pay_q[i]   <= pay_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // Group alignment and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skew_q     <= 8'd0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         skew_err_q <= 1'b0;
      end else begin
         skew_q     <= skew_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
         skew_err_q <= skew_err_d;
      end
   end

   assign pkt_data  = data_q;
   assign pkt_valid = valid_q;
   assign overrun   = overrun_q;
   assign skew_err  = skew_err_q;

endmodule

// File: tb/tb_net_lane_deserializer.sv
// tb_net_lane_deserializer
// Scoreboard bench for net_lane_deserializer with 4 lanes and 16-bit payloads.
// Stimulus pushes each expected packet into a queue. A monitor pops an entry
// and compares it on every pkt_valid && pkt_ready handshake. The monitor also
// counts overrun and skew_err pulses.
module tb_net_lane_deserializer;

   localparam int NL = 4;
   localparam int PB = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NL-1:0] serial_in = '0;
   logic          rx_enable = 1'b1;
   logic          pkt_ready = 1'b0;
   logic [NL*PB-1:0] pkt_data;
   logic          pkt_valid, overrun, skew_err;

   int n_cmp = 0;
   int n_err = 0;
   int valid_cycles = 0;
   int skew_cnt = 0;
   int ovr_cnt = 0;
   logic [63:0] sb[$];

   net_lane_deserializer #(
      .NUM_LANES(NL), .PAYLOAD_BITS(PB), .SYNC_BITS(8),
      .SYNCWORD(8'hff), .SKEW_MAX(16)
   ) dut (
      .clk(clk), .rst(rst), .serial_in(serial_in), .rx_enable(rx_enable),
      .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
      .overrun(overrun), .skew_err(skew_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Lane l sends 0xff then its 16-bit slice of pkt MSB-first. Lane 3 is delayed by d3 cycles.
   task automatic drive_lanes(input logic [63:0] pkt, input int d3, input int tail);
      int len;
      int pos;
      logic [15:0] w;
      len = d3 + 24 + tail;
      for (int t = 0; t < len; t++) begin
         @(negedge clk);
         for (int l = 0; l < NL; l++) begin
            pos = t - ((l == 3) ? d3 : 0);
            w   = pkt[l*PB +: PB];
            if (pos < 0 || pos >= 24) serial_in[l] = 1'b0;
            else if (pos < 8)         serial_in[l] = 1'b1;
            else                      serial_in[l] = w[15 - (pos - 8)];
         end
      end
      @(negedge clk);
      serial_in = '0;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
      check(name, 64'(sb.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   // Monitor: samples 1 time unit after the falling edge, when inputs are stable and well away from the active edge.
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (skew_err) skew_cnt++;
            if (overrun)  ovr_cnt++;
            if (pkt_valid) begin
               valid_cycles++;
               if (pkt_ready) begin
                  if (sb.size() == 0) begin
                     check("expected packet queued", 64'(sb.size()), 64'd1);
                  end else begin
                     exp = sb.pop_front();
                     check("pkt_data at handshake", pkt_data, exp);
                  end
               end
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, s0, o0;
      repeat (3) @(posedge clk);
      #1;
      check("reset pkt_valid", 64'(pkt_valid), 64'd0);
      check("reset pkt_data", pkt_data, 64'd0);
      check("reset overrun", 64'(overrun), 64'd0);
      check("reset skew_err", 64'(skew_err), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // 1: aligned lanes, consumer always ready, so pkt_valid is high for exactly one cycle
      pkt_ready = 1'b1;
      v0 = valid_cycles;
      sb.push_back(64'hA5C3_A5C3_A5C3_A5C3);
      drive_lanes(64'hA5C3_A5C3_A5C3_A5C3, 0, 4);
      wait_drain("t1 drained");
      check("t1 valid cycles", 64'(valid_cycles - v0), 64'd1);

      // 2a: lane 3 late by 5 cycles, inside the skew window
      s0 = skew_cnt;
      sb.push_back(64'h4441_3331_2221_1111);
      drive_lanes(64'h4441_3331_2221_1111, 5, 4);
      wait_drain("t2a drained");
      check("t2a skew_err pulses", 64'(skew_cnt - s0), 64'd0);

      // 2b: lane 3 late by 20 cycles, so skew_err fires and no packet is delivered
      v0 = valid_cycles;
      drive_lanes(64'h4441_3331_2221_1111, 20, 6);
      repeat (4) @(negedge clk);
      check("t2b skew_err pulses", 64'(skew_cnt - s0), 64'd1);
      check("t2b no pkt_valid", 64'(valid_cycles - v0), 64'd0);
      sb.push_back(64'h00F1_00F1_00F1_00F1);
      drive_lanes(64'h00F1_00F1_00F1_00F1, 0, 4);
      wait_drain("t2b recovery drained");

      // 3: two back-to-back packets while stalled; the second is dropped with an overrun pulse
      pkt_ready = 1'b0;
      o0 = ovr_cnt;
      sb.push_back(64'hBEEF_BEEF_BEEF_BEEF);
      drive_lanes(64'hBEEF_BEEF_BEEF_BEEF, 0, 2);
      drive_lanes(64'h0F0F_0F0F_0F0F_0F0F, 0, 4);
      check("t3 overrun pulses", 64'(ovr_cnt - o0), 64'd1);
      check("t3 held pkt_valid", 64'(pkt_valid), 64'd1);
      check("t3 held pkt_data", pkt_data, 64'hBEEF_BEEF_BEEF_BEEF);
      pkt_ready = 1'b1;
      wait_drain("t3 drained");
      check("t3 pkt_valid dropped", 64'(pkt_valid), 64'd0);

      // 4: an all-ones payload must not resync, and the following packet arrives intact
      sb.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      sb.push_back(64'h1234_1234_1234_1234);
      drive_lanes(64'hFFFF_FFFF_FFFF_FFFF, 0, 2);
      drive_lanes(64'h1234_1234_1234_1234, 0, 4);
      wait_drain("t4 drained");

      // rx_enable low mid-packet aborts quietly
      v0 = valid_cycles;
      s0 = skew_cnt;
      fork
         drive_lanes(64'hA5C3_A5C3_A5C3_A5C3, 0, 4);
         begin
            repeat (14) @(negedge clk);
            rx_enable = 1'b0;
            repeat (2) @(negedge clk);
            rx_enable = 1'b1;
         end
      join
      repeat (4) @(negedge clk);
      check("abort no pkt_valid", 64'(valid_cycles - v0), 64'd0);
      check("abort no skew_err", 64'(skew_cnt - s0), 64'd0);

      // 5: rst asserted while the output is FULL and the lanes are mid-RECV
      pkt_ready = 1'b0;
      drive_lanes(64'hC001_C001_C001_C001, 0, 4);
      check("t5 full before reset", 64'(pkt_valid), 64'd1);
      fork
         drive_lanes(64'h7777_7777_7777_7777, 0, 4);
         begin
            repeat (16) @(negedge clk);
            #3 rst = 1'b1;
            #1;
            check("t5 async pkt_valid", 64'(pkt_valid), 64'd0);
            check("t5 async pkt_data", pkt_data, 64'd0);
            check("t5 async overrun", 64'(overrun), 64'd0);
            check("t5 async skew_err", 64'(skew_err), 64'd0);
         end
      join
      @(negedge clk);
      rst = 1'b0;
      pkt_ready = 1'b1;
      sb.push_back(64'h5A5B_5A5B_5A5B_5A5B);
      drive_lanes(64'h5A5B_5A5B_5A5B_5A5B, 0, 4);
      wait_drain("t5 fresh packet drained");

`ifdef NET_RX_LANE_SEQ_CHECK_EN
      // 6: mismatched lane tags discard the group and pulse skew_err
      v0 = valid_cycles;
      s0 = skew_cnt;
      drive_lanes(64'h0000_0001_0001_0001, 0, 4);
      repeat (3) @(negedge clk);
      check("t6 tag skew_err", 64'(skew_cnt - s0), 64'd1);
      check("t6 tag no pkt_valid", 64'(valid_cycles - v0), 64'd0);
      sb.push_back(64'h0003_0003_0003_0003);
      drive_lanes(64'h0003_0003_0003_0003, 0, 4);
      wait_drain("t6 matching tags drained");
`endif

      check("final scoreboard empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
